card_grid_walker: RTL and testbench
===================================

# card_grid_walker

Sequencer that sits directly upstream of the 16x16 tile painter (clear/draw stage) on the card board. It accepts a request naming which slots of a ROWS x COLS card grid must be repainted, and walks that mask in slot order. For each selected slot it issues one start pulse with the tile's top-left pixel coordinate and colour, waits for the painter's completion pulse, then moves on. It signals completion of the whole request with a single pulse.

## Interface
- COLS, 4, grid columns
- ROWS, 4, grid rows; N = ROWS*COLS slots
- X_ORIGIN, 40, x pixel of slot 0 top-left
- Y_ORIGIN, 20, y pixel of slot 0 top-left
- PITCH, 20, pixel stride between adjacent slots, both axes
- TIMEOUT_CYCLES, 512, watchdog limit; used only with the macro

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_mask  in  N  bit i set: repaint slot i (i = row*COLS + col)
- req_colour  in  3  colour for every tile of this request
- req_ready  out  1  high only in IDLE
- tile_start  out  1  one-cycle start pulse to painter
- tile_x0  out  8  tile top-left x
- tile_y0  out  7  tile top-left y
- tile_colour  out  3  latched req_colour
- tile_done  in  1  one-cycle completion pulse from painter
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the request finishes
- cards_left  out  $clog2(N+1)  tiles of the current request not yet completed
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, SCAN, START, WAIT, FINISH.
- IDLE: accept on req_valid && req_ready.
  - Latch mask and colour.
  - idx = 0, row = col = 0.
  - cards_left = popcount(req_mask).
  - Clear timeout_err.
  - Go to SCAN.
- SCAN examines one slot per cycle:
  - Bit idx set: go to START.
  - Bit idx clear, idx == N-1: go to FINISH.
  - Otherwise: advance idx and go to SCAN.
- Advancing idx: col+1; when col == COLS-1, col wraps to 0 and row+1.
- START:
  - tile_start = 1.
  - tile_x0 = X_ORIGIN + col*PITCH, tile_y0 = Y_ORIGIN + row*PITCH, truncated to 8/7 bits.
  - Go to WAIT.
- Coordinates come from the row/col counters; no divider.
- WAIT, on tile_done:
  - Clear the latched mask bit and decrement cards_left.
  - Go to FINISH if idx == N-1, else advance idx and go to SCAN.
- FINISH: done = 1, then IDLE.
- tile_x0, tile_y0 and tile_colour hold stable from START until the next START or reset.
- tile_done outside WAIT is ignored, including the START cycle.
- req_valid outside IDLE is ignored; no queueing.
- Parameter legality, enforced by an elaboration check:
  - X_ORIGIN + (COLS-1)*PITCH + 15 <= 159
  - Y_ORIGIN + (ROWS-1)*PITCH + 15 <= 119
  - PITCH >= 16

## Timing
- Reset values:
  - State IDLE; req_ready = 1.
  - tile_start = 0, tile_x0 = 0, tile_y0 = 0, tile_colour = 0.
  - busy = 0, done = 0, cards_left = 0, timeout_err = 0.
- Reset mid-request: the request is abandoned; no further tile_start and no done pulse.
- Accept at cycle 0 → SCAN idx 0 at cycle 1.
- Each clear slot costs 1 cycle.
- A set slot costs:
  - SCAN: 1 cycle.
  - START: 1 cycle.
  - WAIT: until tile_done.
- tile_done at cycle k → next SCAN, or FINISH, at k+1.
- done is high in the FINISH cycle; req_ready returns the following cycle.
- All outputs are registered.

## Configuration
- CARD_WALKER_TIMEOUT_EN defined:
  - A WAIT cycle counter resets on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES with no tile_done, the block behaves as if tile_done arrived (bit cleared, cards_left decremented, advance).
  - timeout_err is set, and stays set until the next accept or reset.
- CARD_WALKER_TIMEOUT_EN undefined:
  - No counter; WAIT holds indefinitely.
  - timeout_err is tied 0.

## Test plan
- Reset, then mask 16'h0001, colour 3'b000:
  - tile_start at cycle 2 with x0 = 40, y0 = 20.
  - tile_done at cycle 10 → done at cycle 26, cards_left 1→0 at cycle 11, req_ready at cycle 27.
- Mask 16'h0000 → no tile_start; done at cycle 17; cards_left stays 0.
- Mask 16'h8000 → tile_start at cycle 17 with x0 = 100, y0 = 80; tile_done at cycle k → done at k+1.
- Mask 16'hFFFF, painter answers 18 cycles after each start:
  - 16 starts, in raster order.
  - cards_left counts 16→0.
  - Slot 5 gives (60,40).
  - tile_done pulses injected in SCAN are ignored.
- Mask 16'h0003; reset asserted during the first WAIT → all outputs at reset values the next cycle, no further tile_start, no done pulse.
- With CARD_WALKER_TIMEOUT_EN, mask 16'h0001, no tile_done:
  - Timeout fires after 512 WAIT cycles; timeout_err = 1 and done follows.
  - timeout_err clears on the next accept.

Source files
------------

// File: rtl/card_grid_walker.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | card_grid_walker
// | Walks a ROWS x COLS repaint mask in slot order, issuing one painter start per
// | selected slot. Optional WAIT watchdog: define CARD_WALKER_TIMEOUT_EN.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module card_grid_walker #(
  parameter int COLS           = 4,
  parameter int ROWS           = 4,
  parameter int X_ORIGIN       = 40,
  parameter int Y_ORIGIN       = 20,
  parameter int PITCH          = 20,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  input  logic [ROWS*COLS-1:0]             req_mask,
  input  logic [2:0]                       req_colour,
  output logic                             req_ready,
  output logic                             tile_start,
  output logic [7:0]                       tile_x0,
  output logic [6:0]                       tile_y0,
  output logic [2:0]                       tile_colour,
  input  logic                             tile_done,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(ROWS*COLS+1)-1:0]   cards_left,
  output logic                             timeout_err
);

  localparam int c_N     = ROWS * COLS;
  localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
  localparam int c_COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int c_ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_CNT_W = $clog2(c_N + 1);

  if ((X_ORIGIN + (COLS - 1) * PITCH + 15 > 159) ||
      (Y_ORIGIN + (ROWS - 1) * PITCH + 15 > 119) ||
      (PITCH < 16) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("card_grid_walker: illegal grid geometry or timeout parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_N-1:0]       r_mask;
  logic [2:0]           r_colour;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_COL_W-1:0]   r_col;
  logic [c_ROW_W-1:0]   r_row;
  logic [c_CNT_W-1:0]   r_cards_left;
  logic                 r_req_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_tile_start;
  logic [7:0]           r_tile_x0;
  logic [6:0]           r_tile_y0;
  logic [2:0]           r_tile_colour;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_col_wrap;
  logic                 w_wait_expired;
  logic                 w_tile_finished;
  logic [7:0]           w_x0;
  logic [6:0]           w_y0;

  assign w_accept        = req_valid && r_req_ready;
  assign w_last          = (r_idx == c_IDX_W'(c_N - 1));
  assign w_col_wrap      = (r_col == c_COL_W'(COLS - 1));
  assign w_tile_finished = tile_done || w_wait_expired;
  // Constant multiplies by PITCH; modular 8/7-bit arithmetic gives the truncated coordinate.
  assign w_x0 = 8'(X_ORIGIN) + 8'(r_col) * 8'(PITCH);
  assign w_y0 = 7'(Y_ORIGIN) + 7'(r_row) * 7'(PITCH);

`ifdef CARD_WALKER_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TO_W-1:0] r_wait_cnt;
  logic              r_timeout_err;

  assign w_wait_expired = (r_state == S_WAIT) && (r_wait_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err    = r_timeout_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
      if (r_state != S_WAIT) r_wait_cnt <= '0;
      else                   r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
      if (w_accept)                          r_timeout_err <= 1'b0;
      else if (w_wait_expired && !tile_done) r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_wait_expired = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mask        <= '0;
      r_colour      <= '0;
      r_idx         <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_cards_left  <= '0;
      r_req_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_tile_start  <= 1'b0;
      r_tile_x0     <= '0;
      r_tile_y0     <= '0;
      r_tile_colour <= '0;
    end else begin
      r_tile_start <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_SCAN;
            r_mask       <= req_mask;
            r_colour     <= req_colour;
            r_idx        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_cards_left <= c_CNT_W'($countones(req_mask));
            r_req_ready  <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        S_SCAN: begin
          if (r_mask[r_idx]) begin
            r_state       <= S_START;
            r_tile_start  <= 1'b1;
            r_tile_x0     <= w_x0;
            r_tile_y0     <= w_y0;
            r_tile_colour <= r_colour;
          end else if (w_last) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + c_IDX_W'(1);
            if (w_col_wrap) begin
              r_col <= '0;
              r_row <= r_row + c_ROW_W'(1);
            end else begin
              r_col <= r_col + c_COL_W'(1);
            end
          end
        end
        S_START: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_tile_finished) begin
            r_mask[r_idx] <= 1'b0;
            r_cards_left  <= r_cards_left - c_CNT_W'(1);
            if (w_last) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SCAN;
              r_idx   <= r_idx + c_IDX_W'(1);
              if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + c_ROW_W'(1);
              end else begin
                r_col <= r_col + c_COL_W'(1);
              end
            end
          end
        end
        S_FINISH: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign tile_start  = r_tile_start;
  assign tile_x0     = r_tile_x0;
  assign tile_y0     = r_tile_y0;
  assign tile_colour = r_tile_colour;
  assign cards_left  = r_cards_left;

endmodule
`default_nettype wire

// File: tb/tb_card_grid_walker.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_card_grid_walker
// | Directed scoreboard bench: expected start/done events queued, monitor compares.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_card_grid_walker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_mask = '0;
  logic [2:0]  req_colour = '0;
  logic        tile_done = 1'b0;
  logic        req_ready;
  logic        tile_start;
  logic [7:0]  tile_x0;
  logic [6:0]  tile_y0;
  logic [2:0]  tile_colour;
  logic        busy;
  logic        done;
  logic [4:0]  cards_left;
  logic        timeout_err;

  card_grid_walker dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_mask    (req_mask),
    .req_colour  (req_colour),
    .req_ready   (req_ready),
    .tile_start  (tile_start),
    .tile_x0     (tile_x0),
    .tile_y0     (tile_y0),
    .tile_colour (tile_colour),
    .tile_done   (tile_done),
    .busy        (busy),
    .done        (done),
    .cards_left  (cards_left),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0 = tile_start, kind 1 = done; cyc is relative to the accept cycle
  typedef struct {
    int kind;
    int cyc;
    int x;
    int y;
    int col;
    int left;
  } ev_t;

  ev_t sb[$];
  int  base = 0;
  int  n_vec = 0;
  int  n_err = 0;

  int  p_en = 0;
  int  p_delay = 8;
  int  p_hold = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_start(input int c, input int x, input int y, input int col, input int left);
    ev_t e;
    e = '{kind: 0, cyc: c, x: x, y: y, col: col, left: left};
    sb.push_back(e);
  endtask

  task automatic push_done(input int c);
    ev_t e;
    e = '{kind: 1, cyc: c, x: 0, y: 0, col: 0, left: 0};
    sb.push_back(e);
  endtask

  task automatic issue(input logic [15:0] m, input logic [2:0] c);
    base       = cyc;
    req_valid  = 1'b1;
    req_mask   = m;
    req_colour = c;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic wait_ready(input int exp_rel, input string name);
    int n;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, cyc - base, exp_rel);
    chk({name, "_sb_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req_ready"}, int'(req_ready), 1);
    chk({p, "_tile_start"}, int'(tile_start), 0);
    chk({p, "_tile_x0"}, int'(tile_x0), 0);
    chk({p, "_tile_y0"}, int'(tile_y0), 0);
    chk({p, "_tile_colour"}, int'(tile_colour), 0);
    chk({p, "_busy"}, int'(busy), 0);
    chk({p, "_done"}, int'(done), 0);
    chk({p, "_cards_left"}, int'(cards_left), 0);
    chk({p, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  // Painter model: answers p_delay cycles after a start, pulse widened by p_hold cycles
  initial begin
    int  pend;
    bit  pv;
    bit  pulse;
    pend = 0;
    pv   = 1'b0;
    forever begin
      @(negedge clk);
      pulse = 1'b0;
      if (pv && cyc >= pend && cyc <= pend + p_hold) pulse = 1'b1;
      if (pv && cyc >= pend + p_hold) pv = 1'b0;
      if (tile_start && p_en != 0) begin
        pend = cyc + p_delay;
        pv   = 1'b1;
      end
      tile_done = pulse;
    end
  end

  // Monitor: every start/done pulse must match the head of the scoreboard
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (tile_start || done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got start=%0b done=%0b at rel cycle %0d, required none",
                   tile_start, done, cyc - base);
        end else begin
          e = sb.pop_front();
          chk("event_kind", done ? 1 : 0, e.kind);
          chk("event_cycle", cyc - base, e.cyc);
          chk("event_cards_left", int'(cards_left), e.left);
          if (e.kind == 0) begin
            chk("start_x0", int'(tile_x0), e.x);
            chk("start_y0", int'(tile_y0), e.y);
            chk("start_colour", int'(tile_colour), e.col);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset("rst");

    // single tile in slot 0
    p_en = 1; p_delay = 8; p_hold = 0;
    push_start(2, 40, 20, 0, 1);
    push_done(26);
    issue(16'h0001, 3'b000);
    repeat (9) @(negedge clk);
    chk("t1_left_c10", int'(cards_left), 1);
    chk("t1_busy_c10", int'(busy), 1);
    @(negedge clk);
    chk("t1_left_c11", int'(cards_left), 0);
    wait_ready(27, "t1_ready");
    chk("t1_timeout_err", int'(timeout_err), 0);
    repeat (3) @(negedge clk);

    // empty mask
    push_done(17);
    issue(16'h0000, 3'b010);
    chk("t2_left_c1", int'(cards_left), 0);
    wait_ready(18, "t2_ready");
    repeat (3) @(negedge clk);

    // last slot only, with an ignored request while busy
    p_delay = 5;
    push_start(17, 100, 80, 3, 1);
    push_done(23);
    issue(16'h8000, 3'b011);
    repeat (4) @(negedge clk);
    req_valid = 1'b1;
    req_mask  = 16'hFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready(24, "t3_ready");
    repeat (3) @(negedge clk);

    // full grid; tile_done held through SCAN and START after each completion
    p_delay = 18; p_hold = 2;
    for (int i = 0; i < 16; i++)
      push_start(2 + 20 * i, 40 + 20 * (i % 4), 20 + 20 * (i / 4), 6, 16 - i);
    push_done(321);
    issue(16'hFFFF, 3'b110);
    wait_ready(322, "t4_ready");
    repeat (4) @(negedge clk);

    // reset during the first WAIT abandons the request
    p_en = 0; p_hold = 0;
    push_start(2, 40, 20, 5, 2);
    issue(16'h0003, 3'b101);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_sb_drained", sb.size(), 0);
    chk("t5_ready", int'(req_ready), 1);
    sb.delete();

`ifdef CARD_WALKER_TIMEOUT_EN
    // watchdog: 512 WAIT cycles (3..514), then SCAN idx1..15, FINISH at 530
    push_start(2, 40, 20, 1, 1);
    push_done(530);
    issue(16'h0001, 3'b001);
    repeat (513) @(negedge clk);
    chk("t6_err_c514", int'(timeout_err), 0);
    @(negedge clk);
    chk("t6_err_c515", int'(timeout_err), 1);
    chk("t6_left_c515", int'(cards_left), 0);
    wait_ready(531, "t6_ready");
    chk("t6_err_sticky", int'(timeout_err), 1);
    repeat (2) @(negedge clk);
    push_done(17);
    issue(16'h0000, 3'b000);
    chk("t6_err_cleared", int'(timeout_err), 0);
    wait_ready(18, "t6b_ready");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
